// File: rtl/eth_mii_rx_framer_if.sv
// Byte-stream bundle from the MII receive framer to the MAC core.
// Latency: none, wires only.
// Backpressure: ready from the slave stalls valid/data/last/err from the master.
interface eth_mii_rx_framer_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       last;
    logic       err;

    modport master (
        output data,
        output valid,
        output last,
        output err,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        input  err,
        output ready
    );
endinterface

// File: rtl/eth_mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles bytes, checks FCS and length, queues bytes with last/err.
// Latency: a completed byte is written when the next byte completes (or on DV low) and is visible the cycle after.
// Backpressure: m.ready stalls the output FIFO; non-final bytes that do not fit are dropped and the frame is marked bad.
module eth_mii_rx_framer #(
    parameter int FIFO_ADDR_W = 4,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1518
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_dv,
    input  logic [3:0]  rx_data,
    eth_mii_rx_framer_if.master m,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] drop_cnt
);

    localparam int          DEPTH       = 1 << FIFO_ADDR_W;
    localparam int          LEN_W       = $clog2(MAX_LEN + 2);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    // Residue of a good frame (data + FCS) as seen in this register's bit order.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DISCARD
    } state_t;

    // FIFO entry layout: {last, err, data}
    typedef logic [9:0] fifo_word_t;

    state_t                 state;
    logic [31:0]            crc;
    logic [LEN_W-1:0]       len;
    logic                   phase;      // 0: expecting low nibble, 1: expecting high nibble
    logic [3:0]             lo_nib;
    logic                   stage_vld;
    logic [7:0]             stage_dat;
    logic                   ovf;

    logic [FIFO_ADDR_W-1:0] wr_ptr;
    logic [FIFO_ADDR_W-1:0] rd_ptr;
    logic [FIFO_ADDR_W-1:0] occ;
    logic                   room2;
    logic                   pop;
    fifo_word_t             mem [DEPTH];
    fifo_word_t             rd_word;

    logic [7:0]             byte_dat;
    logic                   byte_done;
    logic                   frame_end;
    logic                   frame_err;
    logic                   push_en;
    fifo_word_t             push_word;

    // Data bits enter LSB first; the register is kept MSB-first, so the
    // good-frame residue is the bit-reversed form of the usual 0xDEBB20E3.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ring pointers without an extra wrap bit: one slot is always left free,
    // so the usable capacity is DEPTH-1 entries.
    assign occ   = wr_ptr - rd_ptr;
    // A non-final push must leave one free slot behind it for the closing byte.
    assign room2 = (occ <= FIFO_ADDR_W'(DEPTH - 3));

    assign rd_word  = mem[rd_ptr];
    assign m.valid  = (occ != '0);
    assign m.data   = m.valid ? rd_word[7:0] : 8'h00;
    assign m.err    = m.valid ? rd_word[8]   : 1'b0;
    assign m.last   = m.valid ? rd_word[9]   : 1'b0;
    assign pop      = m.valid & m.ready;

    // Decode this cycle's byte completion, frame close and FIFO write.
    always_comb begin
        byte_dat  = {rx_data, lo_nib};
        byte_done = (state == S_DATA) && rx_dv && phase;
        frame_end = (state == S_DATA) && !rx_dv;
        frame_err = (crc != CRC_RESIDUE)
                  || (len < LEN_W'(MIN_LEN))
                  || (len > LEN_W'(MAX_LEN))
                  || phase
                  || ovf;
        push_en   = 1'b0;
        push_word = '0;
        if (byte_done && stage_vld && room2) begin
            push_en   = 1'b1;
            push_word = {1'b0, 1'b0, stage_dat};
        end else if (frame_end && stage_vld) begin
            push_en   = 1'b1;
            push_word = {1'b1, frame_err, stage_dat};
        end
    end

    // FIFO storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers; push and pop may coincide at any occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Framing FSM with byte assembly, CRC, length, staging and counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            crc       <= CRC_INIT;
            len       <= '0;
            phase     <= 1'b0;
            lo_nib    <= 4'h0;
            stage_vld <= 1'b0;
            stage_dat <= 8'h00;
            ovf       <= 1'b0;
            frame_cnt <= 16'h0000;
            err_cnt   <= 16'h0000;
            drop_cnt  <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_dv) begin
                        if (rx_data == 4'h5) begin
                            state <= S_PREAMBLE;
                        end else begin
                            state    <= S_DISCARD;
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                end

                S_PREAMBLE: begin
                    if (!rx_dv) begin
                        state    <= S_IDLE;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if (rx_data == 4'hD) begin
                        state     <= S_DATA;
                        crc       <= CRC_INIT;
                        len       <= '0;
                        phase     <= 1'b0;
                        stage_vld <= 1'b0;
                        ovf       <= 1'b0;
                    end else if (rx_data != 4'h5) begin
                        state    <= S_DISCARD;
                        drop_cnt <= sat_inc(drop_cnt);
                    end
                end

                S_DATA: begin
                    if (rx_dv) begin
                        if (!phase) begin
                            lo_nib <= rx_data;
                            phase  <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            crc   <= crc_byte(crc, byte_dat);
                            if (len != LEN_W'(MAX_LEN + 1)) begin
                                len <= len + 1'b1;
                            end
                            if (!stage_vld) begin
                                stage_vld <= 1'b1;
                                stage_dat <= byte_dat;
                            end else if (room2) begin
                                // Staged byte goes out this cycle; the new one replaces it.
                                stage_dat <= byte_dat;
                            end else begin
                                // No room: keep the staged byte for the closing push.
                                ovf <= 1'b1;
                            end
                        end
                    end else begin
                        state     <= S_IDLE;
                        stage_vld <= 1'b0;
                        if (stage_vld) begin
                            frame_cnt <= sat_inc(frame_cnt);
                            if (frame_err) begin
                                err_cnt <= sat_inc(err_cnt);
                            end
                        end else begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                end

                S_DISCARD: begin
                    if (!rx_dv) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_mii_rx_framer.sv
// Bench for eth_mii_rx_framer: table of frames, hand-built corner sequences, randomized frames vs a frame-level model.
// Latency: outputs are sampled on the falling edge, inputs driven there too.
// Backpressure: m_ready is driven per cycle from a selectable pattern.
module tb_eth_mii_rx_framer;

    typedef byte unsigned bq_t[$];

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } out_t;

    typedef struct {
        int len;
        int flip;
        bit odd;
        bit exp_err;
        int exp_fc;
        int exp_ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_dv = 1'b0;
    logic [3:0]  rx_data = 4'h0;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;

    eth_mii_rx_framer_if m_if ();

    eth_mii_rx_framer #(
        .FIFO_ADDR_W (4),
        .MIN_LEN     (64),
        .MAX_LEN     (1518)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_dv     (rx_dv),
        .rx_data   (rx_data),
        .m         (m_if),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;   // 0 always, 1 never, 2 toggle, 3 random but at least every other cycle
    int unsigned cyc = 0;
    out_t        cap[$];

    // Consumer: choose m_ready for the coming edge and record the byte it will pop.
    always @(negedge clk) begin
        cyc = cyc + 1;
        case (ready_mode)
            0:       m_if.ready = 1'b1;
            1:       m_if.ready = 1'b0;
            2:       m_if.ready = cyc[0];
            default: m_if.ready = cyc[0] | 1'($urandom_range(0, 1));
        endcase
        if (m_if.valid && m_if.ready) begin
            cap.push_back({m_if.data, m_if.last, m_if.err});
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Standard Ethernet CRC-32 (reflected, init all ones, final inversion).
    function automatic logic [31:0] crc32(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic bq_t build_frame(input int len, input int flip, input bit rnd);
        bq_t         b;
        logic [31:0] f;
        logic [7:0]  v;
        for (int i = 0; i < len - 4; i++) begin
            if (rnd) v = 8'($urandom);
            else     v = (i < 6) ? 8'hFF : 8'h00;
            b.push_back(v);
        end
        f = crc32(b);
        b.push_back(f[7:0]);
        b.push_back(f[15:8]);
        b.push_back(f[23:16]);
        b.push_back(f[31:24]);
        if (flip >= 0) b[flip] = b[flip] ^ 8'h01;
        return b;
    endfunction

    // Frame-level verdict: FCS must match the body, length in range, whole bytes only.
    function automatic bit model_err(input bq_t b, input bit odd);
        bq_t         body;
        logic [31:0] rx_fcs;
        int          n;
        n = b.size();
        for (int i = 0; i < n - 4; i++) body.push_back(b[i]);
        rx_fcs = {b[n-1], b[n-2], b[n-3], b[n-4]};
        return (crc32(body) != rx_fcs) || (n < 64) || (n > 1518) || odd;
    endfunction

    task automatic drive(input logic dv, input logic [3:0] d);
        @(negedge clk);
        rx_dv   = dv;
        rx_data = d;
    endtask

    // Preamble + SFD, bytes low nibble first, optional stray nibble, then idle gap.
    // cut >= 0 stops after that many bytes with DV still high.
    task automatic send(input bq_t b, input bit odd, input int gap, input int cut);
        logic [7:0] v;
        for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
        for (int i = 0; i < b.size(); i++) begin
            if (cut >= 0 && i == cut) return;
            v = b[i];
            drive(1'b1, v[3:0]);
            drive(1'b1, v[7:4]);
        end
        if (odd) drive(1'b1, 4'hA);
        for (int i = 0; i < gap; i++) drive(1'b0, 4'h0);
    endtask

    task automatic drain();
        int i;
        repeat (3) @(negedge clk);
        for (i = 0; i < 4000 && m_if.valid; i++) @(negedge clk);
        chk("drain_timeout", m_if.valid, 0);
    endtask

    // Pull one frame (up to and including m_last) from the capture queue and compare.
    task automatic check_frame(input string nm, input bq_t exp, input bit exp_err);
        out_t o;
        int   k;
        int   mm;
        bit   found;
        logic errv;
        k = 0; mm = 0; found = 0; errv = 1'bx;
        while (cap.size() > 0 && !found) begin
            o = cap.pop_front();
            if (k < exp.size() && o.d !== exp[k]) mm++;
            if (!o.last && o.err) mm++;
            k++;
            if (o.last) begin
                found = 1;
                errv  = o.err;
            end
        end
        chk({nm, "_len"}, k, exp.size());
        chk({nm, "_data"}, mm, 0);
        chk({nm, "_last"}, found, 1);
        chk({nm, "_err"}, errv, exp_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn  = 1'b0;
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        cap.delete();
    endtask

    initial begin
        vec_t tbl[7];
        bq_t  f1, f2, sub;
        bq_t  flat;
        int   lens[$];
        bit   errs[$];
        int   fc0, ec0, n_err;

        tbl[0] = '{64,   -1, 0, 0, 1, 0};
        tbl[1] = '{64,   34, 0, 1, 2, 1};
        tbl[2] = '{40,   -1, 0, 1, 3, 2};
        tbl[3] = '{1519, -1, 0, 1, 4, 3};
        tbl[4] = '{64,   -1, 1, 1, 5, 4};
        tbl[5] = '{1518, -1, 0, 0, 6, 4};
        tbl[6] = '{63,   -1, 0, 1, 7, 5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", m_if.valid, 0);
        chk("rst_data", m_if.data, 0);
        chk("rst_last", m_if.last, 0);
        chk("rst_err", m_if.err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rstn = 1'b1;
        ready_mode = 0;
        @(negedge clk);

        // Table-driven frames
        for (int t = 0; t < 7; t++) begin
            f1 = build_frame(tbl[t].len, tbl[t].flip, 1'b0);
            send(f1, tbl[t].odd, 2, -1);
            drain();
            check_frame($sformatf("vec%0d", t), f1, tbl[t].exp_err);
            chk($sformatf("vec%0d_frame_cnt", t), frame_cnt, tbl[t].exp_fc);
            chk($sformatf("vec%0d_err_cnt", t), err_cnt, tbl[t].exp_ec);
        end
        chk("table_drop_cnt", drop_cnt, 0);

        // Bad preamble nibble, DV held, then a good frame
        drive(1'b1, 4'h5);
        drive(1'b1, 4'h5);
        drive(1'b1, 4'h7);
        for (int i = 0; i < 20; i++) drive(1'b1, 4'(i));
        drive(1'b0, 4'h0);
        repeat (5) @(negedge clk);
        chk("badpre_no_output", cap.size(), 0);
        chk("badpre_drop_cnt", drop_cnt, 1);
        f1 = build_frame(64, -1, 1'b0);
        send(f1, 1'b0, 1, -1);
        drain();
        check_frame("after_badpre", f1, 1'b0);
        chk("after_badpre_frame_cnt", frame_cnt, 8);

        // Consumer stalled for a whole frame
        ready_mode = 1;
        f1 = build_frame(64, -1, 1'b0);
        send(f1, 1'b0, 1, -1);
        repeat (20) @(negedge clk);
        chk("stall_no_pop", cap.size(), 0);
        chk("stall_valid", m_if.valid, 1);
        chk("stall_err_cnt", err_cnt, 6);
        sub.delete();
        for (int i = 0; i < 15; i++) sub.push_back(f1[i]);
        ready_mode = 0;
        drain();
        check_frame("stall", sub, 1'b1);

        // Back-to-back frames, toggling ready
        do_reset();
        chk("rst2_frame_cnt", frame_cnt, 0);
        ready_mode = 2;
        f1 = build_frame(64, -1, 1'b1);
        f2 = build_frame(70, -1, 1'b1);
        send(f1, 1'b0, 1, -1);
        send(f2, 1'b0, 1, -1);
        drain();
        check_frame("b2b_0", f1, 1'b0);
        check_frame("b2b_1", f2, 1'b0);
        chk("b2b_frame_cnt", frame_cnt, 2);
        chk("b2b_err_cnt", err_cnt, 0);

        // Reset in the middle of the second frame
        send(f1, 1'b0, 1, -1);
        send(f2, 1'b0, 1, 10);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_valid", m_if.valid, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        cap.delete();
        repeat (30) @(negedge clk);
        chk("midrst_no_partial", cap.size(), 0);

        // Randomized frames against the frame-level model
        ready_mode = 3;
        fc0 = frame_cnt;
        ec0 = err_cnt;
        n_err = 0;
        for (int r = 0; r < 10; r++) begin
            int len;
            bit odd;
            len = ($urandom_range(0, 1) == 1) ? $urandom_range(64, 100) : $urandom_range(20, 63);
            f1 = build_frame(len, -1, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                int idx;
                idx = $urandom_range(0, len - 1);
                f1[idx] = f1[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
            odd = ($urandom_range(0, 4) == 0);
            foreach (f1[i]) flat.push_back(f1[i]);
            lens.push_back(len);
            errs.push_back(model_err(f1, odd));
            if (model_err(f1, odd)) n_err++;
            send(f1, odd, $urandom_range(1, 3), -1);
        end
        drain();
        for (int r = 0; r < 10; r++) begin
            sub.delete();
            for (int i = 0; i < lens[r]; i++) sub.push_back(flat.pop_front());
            check_frame($sformatf("rnd%0d", r), sub, errs[r]);
        end
        chk("rnd_frame_cnt", frame_cnt, fc0 + 10);
        chk("rnd_err_cnt", err_cnt, ec0 + n_err);
        chk("rnd_leftover", cap.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
